// File: rtl/pipe_tap_reg_mux.sv
// pipe_tap_reg_mux: DEPTH-stage delay line with run-time output tap, per-word valid and occupancy.
// Optional feature macro PIPE_TAP_PARITY_EN adds per-stage even parity and a sticky Parity_Err output.

module pipe_tap_reg_mux_chk #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input logic             Clk,
  input logic             Rst,
  input logic [DEPTH-1:0] valid,
  input logic [CNT_W-1:0] occupancy
);

  // Occupancy must always equal the number of valid stages
  occ_matches_popcount: assert property (@(posedge Clk) disable iff (Rst)
    $countones(valid) == int'(occupancy));

endmodule

module pipe_tap_reg_mux #(
  parameter int  WIDTH = 18,
  parameter int  DEPTH = 4,
  localparam int SEL_W = $clog2(DEPTH + 1),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Enable,
  input  logic             Clr,
  input  logic [WIDTH-1:0] In,
  input  logic             In_Valid,
  input  logic [SEL_W-1:0] Tap,
  output logic [WIDTH-1:0] Out,
  output logic             Out_Valid,
  output logic [CNT_W-1:0] Occupancy,
  output logic             Empty
`ifdef PIPE_TAP_PARITY_EN
  ,
  output logic             Parity_Err
`endif
);

  function automatic logic even_parity(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction

  logic [WIDTH-1:0] data_r [DEPTH];
  logic [DEPTH-1:0] valid_r;
  logic [CNT_W-1:0] occ_r;
  logic [SEL_W-1:0] tap_idx_s;
  logic [WIDTH:0]   tap_vec_s [DEPTH+1];

  // Stage data/valid shift register; bubbles are stored with valid low
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int k = 0; k < DEPTH; k++) data_r[k] <= {WIDTH{1'b0}};
      valid_r <= {DEPTH{1'b0}};
    end else if (Clr) begin
      for (int k = 0; k < DEPTH; k++) data_r[k] <= {WIDTH{1'b0}};
      valid_r <= {DEPTH{1'b0}};
    end else if (Enable) begin
      data_r[0]  <= In;
      valid_r[0] <= In_Valid;
      for (int k = 1; k < DEPTH; k++) begin
        data_r[k]  <= data_r[k-1];
        valid_r[k] <= valid_r[k-1];
      end
    end
  end

  // Occupancy tracks entering minus leaving valid words; range stays 0..DEPTH
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      occ_r <= {CNT_W{1'b0}};
    end else if (Clr) begin
      occ_r <= {CNT_W{1'b0}};
    end else if (Enable) begin
      occ_r <= occ_r + CNT_W'(In_Valid) - CNT_W'(valid_r[DEPTH-1]);
    end
  end

  // Tap mux: index 0 is the bypass, out-of-range taps clamp to the last stage
  always_comb begin
    tap_vec_s[0] = {In_Valid, In};
    for (int k = 1; k <= DEPTH; k++) begin
      tap_vec_s[k] = {valid_r[k-1], data_r[k-1]};
    end
    if (Tap > SEL_W'(DEPTH)) begin
      tap_idx_s = SEL_W'(DEPTH);
    end else begin
      tap_idx_s = Tap;
    end
    {Out_Valid, Out} = tap_vec_s[tap_idx_s];
  end

  assign Occupancy = occ_r;
  assign Empty     = (occ_r == {CNT_W{1'b0}});

`ifdef PIPE_TAP_PARITY_EN
  logic [DEPTH-1:0] par_r;
  logic             par_err_r;
  logic             par_mismatch_s;

  // Parity bits travel alongside the data they protect
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      par_r <= {DEPTH{1'b0}};
    end else if (Clr) begin
      par_r <= {DEPTH{1'b0}};
    end else if (Enable) begin
      par_r[0] <= even_parity(In);
      for (int k = 1; k < DEPTH; k++) par_r[k] <= par_r[k-1];
    end
  end

  // Only valid stages can raise a parity error
  always_comb begin
    par_mismatch_s = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      par_mismatch_s = par_mismatch_s | (valid_r[k] & (even_parity(data_r[k]) ^ par_r[k]));
    end
  end

  // Sticky error flag, cleared only by reset or Clr
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      par_err_r <= 1'b0;
    end else if (Clr) begin
      par_err_r <= 1'b0;
    end else begin
      par_err_r <= par_err_r | par_mismatch_s;
    end
  end

  assign Parity_Err = par_err_r;
`endif

  pipe_tap_reg_mux_chk #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_chk (
    .Clk       (Clk),
    .Rst       (Rst),
    .valid     (valid_r),
    .occupancy (occ_r)
  );

endmodule

// File: tb/tb_pipe_tap_reg_mux.sv
// Randomized self-checking bench for pipe_tap_reg_mux against a history-array reference model.

module tb_pipe_tap_reg_mux;

  localparam int WIDTH = 18;
  localparam int DEPTH = 4;
  localparam int SEL_W = $clog2(DEPTH + 1);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             Clk = 1'b0;
  logic             Rst;
  logic             Enable;
  logic             Clr;
  logic [WIDTH-1:0] In;
  logic             In_Valid;
  logic [SEL_W-1:0] Tap;
  logic [WIDTH-1:0] Out;
  logic             Out_Valid;
  logic [CNT_W-1:0] Occupancy;
  logic             Empty;
`ifdef PIPE_TAP_PARITY_EN
  logic             Parity_Err;
`endif

  pipe_tap_reg_mux #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Enable    (Enable),
    .Clr       (Clr),
    .In        (In),
    .In_Valid  (In_Valid),
    .Tap       (Tap),
    .Out       (Out),
    .Out_Valid (Out_Valid),
    .Occupancy (Occupancy),
`ifdef PIPE_TAP_PARITY_EN
    .Parity_Err(Parity_Err),
`endif
    .Empty     (Empty)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_pass   = 0;

  // history[i] = {valid, data} of the word accepted i+1 enabled edges ago
  logic [WIDTH:0] history [DEPTH];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [WIDTH:0] model_tap();
    int k;
    k = (int'(Tap) > DEPTH) ? DEPTH : int'(Tap);
    if (k == 0) return {In_Valid, In};
    return history[k-1];
  endfunction

  function automatic int model_occ();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) c += int'(history[i][WIDTH]);
    return c;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) history[i] = '0;
  endtask

  task automatic model_edge();
    if (Rst || Clr) begin
      model_clear();
    end else if (Enable) begin
      for (int k = DEPTH - 1; k > 0; k--) history[k] = history[k-1];
      history[0] = {In_Valid, In};
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [WIDTH:0] e;
    e = model_tap();
    check_val({tag, ".out"},       64'(Out),       64'(e[WIDTH-1:0]));
    check_val({tag, ".out_valid"}, 64'(Out_Valid), 64'(e[WIDTH]));
    check_val({tag, ".occ"},       64'(Occupancy), 64'(model_occ()));
    check_val({tag, ".empty"},     64'(Empty),     64'(model_occ() == 0));
`ifdef PIPE_TAP_PARITY_EN
    check_val({tag, ".perr"},      64'(Parity_Err), 64'(0));
`endif
  endtask

  // Called just after a falling edge with inputs already driven
  task automatic cycle(input string tag);
    #1 check_outputs(tag);
    @(posedge Clk);
    model_edge();
    @(negedge Clk);
  endtask

  task automatic async_rst_pulse();
    #3 Rst = 1'b1;
    #1;
    model_clear();
    check_val("arst.occ",   64'(Occupancy), 64'(0));
    check_val("arst.empty", 64'(Empty),     64'(1));
    check_outputs("arst");
    @(posedge Clk);
    model_edge();
    @(negedge Clk);
    Rst = 1'b0;
  endtask

  initial begin
    model_clear();
    Rst = 1'b1; Enable = 1'b0; Clr = 1'b0;
    In = 18'h155; In_Valid = 1'b1; Tap = 3'd2;
    #2;
    check_val("rst.out",       64'(Out),       64'(0));
    check_val("rst.out_valid", 64'(Out_Valid), 64'(0));
    check_val("rst.occ",       64'(Occupancy), 64'(0));
    check_val("rst.empty",     64'(Empty),     64'(1));
    repeat (2) @(negedge Clk);
    Rst = 1'b0;

    Tap = 3'd0; In = 18'h3FFFF; In_Valid = 1'b1;
    #1;
    check_val("bypass.out",       64'(Out),       64'(18'h3FFFF));
    check_val("bypass.out_valid", 64'(Out_Valid), 64'(1));
    @(negedge Clk);

    Tap = 3'd3; Enable = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      In = WIDTH'(i); In_Valid = 1'b1;
      cycle("stream");
    end
    #1;
    check_val("stream.tail", 64'(Out),       64'(3));
    check_val("stream.occ4", 64'(Occupancy), 64'(DEPTH));

    Enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      In = WIDTH'($urandom); In_Valid = 1'($urandom);
      cycle("hold");
    end
    Enable = 1'b1;
    for (int i = 6; i <= 9; i++) begin
      In = WIDTH'(i); In_Valid = 1'b1;
      cycle("resume");
    end

    Clr = 1'b1; Enable = 1'b1; In = 18'd9; In_Valid = 1'b1;
    cycle("clr");
    Clr = 1'b0; Enable = 1'b0; Tap = 3'd1;
    #1;
    check_val("clr.occ",       64'(Occupancy), 64'(0));
    check_val("clr.empty",     64'(Empty),     64'(1));
    check_val("clr.out_valid", 64'(Out_Valid), 64'(0));
    check_val("clr.out",       64'(Out),       64'(0));
    @(negedge Clk);

    Tap = 3'd7; Enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      In = WIDTH'($urandom); In_Valid = (i % 3) != 0;
      cycle("tap7");
    end

    for (int n = 0; n < 400; n++) begin
      Enable   = ($urandom_range(0, 3) != 0);
      Clr      = ($urandom_range(0, 24) == 0);
      In       = WIDTH'($urandom);
      In_Valid = ($urandom_range(0, 2) != 0);
      Tap      = SEL_W'($urandom_range(0, 7));
      if ($urandom_range(0, 59) == 0) async_rst_pulse();
      else cycle("rand");
    end
    Clr = 1'b0;

`ifdef PIPE_TAP_PARITY_EN
    begin
      logic [WIDTH-1:0] bad;
      Enable = 1'b1; Tap = 3'd1;
      for (int i = 0; i < DEPTH; i++) begin
        In = WIDTH'($urandom); In_Valid = 1'b1;
        cycle("pfill");
      end
      Enable = 1'b0;
      bad = dut.data_r[1] ^ 18'h1;
      force dut.data_r[1] = bad;
      @(posedge Clk); #1;
      check_val("perr.set", 64'(Parity_Err), 64'(1));
      release dut.data_r[1];
      @(negedge Clk);
      check_val("perr.sticky", 64'(Parity_Err), 64'(1));
      Clr = 1'b1;
      @(posedge Clk); #1;
      check_val("perr.clr", 64'(Parity_Err), 64'(0));
      model_clear();
      @(negedge Clk);
      Clr = 1'b0;
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
